// File: rtl/mat_pkg.sv
// Shared types for the matrix cache read path: cache read opcodes and the
// streamer's sweep states.
package mat_pkg;

  typedef enum logic [1:0] {
    READ_DIAG = 2'd0,
    READ_ROW  = 2'd1,
    READ_COL  = 2'd2
  } MatCacheReadOp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } StreamerState_t;

endpackage

// File: rtl/mat_stream_out_reg.sv
// Output holding register for one streamed vector: captures data/index/last on
// load and holds them, with valid, until the streamer clears it.
module mat_stream_out_reg #(
  parameter int WIDTH   = 128,
  parameter int INDEX_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               clear,
  input  shortreal           in_data [WIDTH],
  input  logic [INDEX_W-1:0] in_index,
  input  logic               in_last,
  output logic               out_valid,
  output shortreal           out_data [WIDTH],
  output logic [INDEX_W-1:0] out_index,
  output logic               out_last
);

  // NOTE: this is a WIDTH-wide register, not a RAM, so every element is reset;
  // a real memory array would be left unreset to stay mappable to RAM macros.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) out_data[i] <= 0.0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_index <= in_index;
      out_last  <= in_last;
      for (int i = 0; i < WIDTH; i++) out_data[i] <= in_data[i];
    end
  end

endmodule

// File: rtl/mat_cache_streamer.sv
// Read-side sweep sequencer: steps the matrix cache read port once per vector
// and streams vectors out over valid/ready. MAT_CACHE_STREAMER_ABORT_EN adds an abort input.
module mat_cache_streamer
  import mat_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_SIZE      = 4,
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset_n,
`ifdef MAT_CACHE_STREAMER_ABORT_EN
  input  logic                       abort,
`endif
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  MatCacheReadOp_t            cmd_op,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
  input  logic [WIDTH_ADDR_SIZE-1:0] cmd_start,
  input  logic [WIDTH_ADDR_SIZE:0]   cmd_count,
  output MatCacheReadOp_t            rd_op,
  output logic [CACHE_ADDR_SIZE-1:0] rd_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] rd_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0] rd_param,
  input  shortreal                   rd_data [WIDTH],
  output logic                       out_valid,
  input  logic                       out_ready,
  output shortreal                   out_data [WIDTH],
  output logic [WIDTH_ADDR_SIZE-1:0] out_index,
  output logic                       out_last,
  output logic                       done
);

  typedef struct packed {
    MatCacheReadOp_t            op;
    logic [CACHE_ADDR_SIZE-1:0] addr1;
    logic [CACHE_ADDR_SIZE-1:0] addr2;
    logic [WIDTH_ADDR_SIZE-1:0] start;
    logic [WIDTH_ADDR_SIZE:0]   count;
  } MatStreamCmd_t;

  localparam logic [WIDTH_ADDR_SIZE:0]   COUNT_MAX  = (WIDTH_ADDR_SIZE+1)'(WIDTH);
  localparam logic [WIDTH_ADDR_SIZE:0]   REM_ONE    = (WIDTH_ADDR_SIZE+1)'(1);
  localparam logic [WIDTH_ADDR_SIZE-1:0] PARAM_ONE  = WIDTH_ADDR_SIZE'(1);
  localparam logic [WIDTH_ADDR_SIZE-1:0] PARAM_LAST = WIDTH_ADDR_SIZE'(WIDTH - 1);

  StreamerState_t             state_q, state_d;
  MatStreamCmd_t              cmd_in;
  MatCacheReadOp_t            op_q;
  logic [CACHE_ADDR_SIZE-1:0] addr1_q, addr2_q;
  logic [WIDTH_ADDR_SIZE-1:0] param_q;
  logic [WIDTH_ADDR_SIZE:0]   remaining_q, count_clamped;
  logic                       accept, load, clear, done_d;

  assign cmd_in        = '{op: cmd_op, addr1: cmd_addr1, addr2: cmd_addr2,
                           start: cmd_start, count: cmd_count};
  assign count_clamped = (cmd_in.count > COUNT_MAX) ? COUNT_MAX : cmd_in.count;
  assign cmd_ready     = (state_q == IDLE);
  assign accept        = cmd_valid && cmd_ready;

  assign rd_op    = op_q;
  assign rd_addr1 = addr1_q;
  assign rd_addr2 = addr2_q;
  assign rd_param = param_q;

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = (count_clamped == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (remaining_q != '0 && (!out_valid || out_ready)) begin
          load = 1'b1;
          if (remaining_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          clear   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MAT_CACHE_STREAMER_ABORT_EN
    // Abort wins over any same-cycle handshake and suppresses done.
    if (abort && state_q != IDLE) begin
      load    = 1'b0;
      clear   = 1'b1;
      done_d  = 1'b0;
      state_d = IDLE;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= READ_ROW;
      addr1_q     <= '0;
      addr2_q     <= '0;
      param_q     <= '0;
      remaining_q <= '0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (accept) begin
        op_q        <= cmd_in.op;
        addr1_q     <= cmd_in.addr1;
        addr2_q     <= cmd_in.addr2;
        param_q     <= cmd_in.start;
        remaining_q <= count_clamped;
      end else if (load) begin
        param_q     <= (param_q == PARAM_LAST) ? '0 : param_q + PARAM_ONE;
        remaining_q <= remaining_q - REM_ONE;
      end
    end
  end

  mat_stream_out_reg #(
    .WIDTH   (WIDTH),
    .INDEX_W (WIDTH_ADDR_SIZE)
  ) u_out_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .clear     (clear),
    .in_data   (rd_data),
    .in_index  (param_q),
    .in_last   (remaining_q == REM_ONE),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule
